// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with optional skid entry,
// synchronous flush and a saturating count of flushed entries.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       SKID       = 1,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [31:0]       out_pc,
  output logic [1:0]        occupancy,
  output logic [15:0]       drop_count
);

  localparam logic [DATA_W+31:0] RST_EXT = {32'd0, RESET_DATA};
  localparam logic [31:0] RESET_PC = RST_EXT[31:0];

  logic              m_v_q, m_v_d;
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [31:0]       m_pc_q, m_pc_d;
  logic [31:0]       s_pc_q, s_pc_d;
  logic [15:0]       drop_q, drop_d;

  logic        accept;
  logic        emit;
  logic [1:0]  drop_inc;
  logic [16:0] drop_sum;

  assign in_ready = (SKID != 0) ? !s_v_q : (!m_v_q | out_ready);

  always_comb begin
    accept   = in_valid & in_ready;
    emit     = m_v_q & out_ready;
    m_v_d    = m_v_q;
    s_v_d    = s_v_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    m_pc_d   = m_pc_q;
    s_pc_d   = s_pc_q;
    drop_d   = drop_q;
    drop_inc = {1'b0, m_v_q & ~out_ready} + {1'b0, s_v_q};
    drop_sum = {1'b0, drop_q} + {15'd0, drop_inc};

    if (flush) begin
      // an entry leaving this edge counts as delivered, not dropped
      m_v_d    = 1'b0;
      s_v_d    = 1'b0;
      m_data_d = RESET_DATA;
      s_data_d = RESET_DATA;
      m_pc_d   = RESET_PC;
      s_pc_d   = RESET_PC;
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end else if (SKID == 0) begin
      if (accept) begin
        m_v_d    = 1'b1;
        m_data_d = in_data;
        m_pc_d   = in_pc;
      end else if (emit) begin
        m_v_d = 1'b0;
      end
    end else if (!m_v_q) begin
      if (accept) begin
        m_v_d    = 1'b1;
        m_data_d = in_data;
        m_pc_d   = in_pc;
      end
    end else if (emit) begin
      if (s_v_q) begin
        s_v_d    = 1'b0;
        m_data_d = s_data_q;
        m_pc_d   = s_pc_q;
      end else if (accept) begin
        m_data_d = in_data;
        m_pc_d   = in_pc;
      end else begin
        m_v_d = 1'b0;
      end
    end else if (accept) begin
      s_v_d    = 1'b1;
      s_data_d = in_data;
      s_pc_d   = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_v_q    <= 1'b0;
      s_v_q    <= 1'b0;
      m_data_q <= RESET_DATA;
      s_data_q <= RESET_DATA;
      m_pc_q   <= RESET_PC;
      s_pc_q   <= RESET_PC;
      drop_q   <= 16'd0;
    end else begin
      m_v_q    <= m_v_d;
      s_v_q    <= s_v_d;
      m_data_q <= m_data_d;
      s_data_q <= s_data_d;
      m_pc_q   <= m_pc_d;
      s_pc_q   <= s_pc_d;
      drop_q   <= drop_d;
    end
  end

  assign out_valid  = m_v_q;
  assign out_data   = m_data_q;
  assign out_pc     = m_pc_q;
  assign occupancy  = {1'b0, m_v_q} + {1'b0, s_v_q};
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid and single-entry
// instances driven from shared stimulus.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic [31:0] in_pc;

  logic        rdy1, ov1, rdy0, ov0;
  logic [15:0] od1, od0, dc1, dc0;
  logic [31:0] opc1, opc0;
  logic [1:0]  occ1, occ0;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] RD = 16'hA5A5;
  localparam logic [31:0] RPC = 32'h0000_A5A5;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(16), .SKID(1), .RESET_DATA(RD)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_pc(in_pc),
    .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_pc(opc1),
    .occupancy(occ1), .drop_count(dc1)
  );

  pipe_stage_buf #(.DATA_W(16), .SKID(0), .RESET_DATA(16'h0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_pc(in_pc),
    .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_pc(opc0),
    .occupancy(occ0), .drop_count(dc0)
  );

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [15:0] d;
    logic        ev;
    logic [31:0] epc;
    logic [15:0] ed;
    logic [1:0]  eocc;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc,
                       input logic [15:0] d, input logic ordy,
                       input logic fl);
    in_valid  = iv;
    in_pc     = pc;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic fill_flush(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 32'h500 + k, 16'h55, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    step();
    flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      vt[i].iv   = 1'b1;
      vt[i].pc   = 32'h100 + 32'(i * 4);
      vt[i].d    = 16'(16'h1000 + i);
      vt[i].ev   = 1'b1;
      vt[i].epc  = 32'h100 + 32'(i * 4);
      vt[i].ed   = 16'(16'h1000 + i);
      vt[i].eocc = 2'd1;
    end
    vt[8] = '{1'b0, 32'h0, 16'h0, 1'b0, 32'h11C, 16'h1007, 2'd0};

    reset = 1'b1;
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", 32'(ov1), 32'd0);
    chk("rst_data", 32'(od1), 32'(RD));
    chk("rst_pc", opc1, RPC);
    chk("rst_occ", 32'(occ1), 32'd0);
    chk("rst_drop", 32'(dc1), 32'd0);
    chk("rst_ready1", 32'(rdy1), 32'd1);
    chk("rst_ready0", 32'(rdy0), 32'd1);

    // streaming through both variants
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].iv, vt[i].pc, vt[i].d, 1'b1, 1'b0);
      #1;
      chk($sformatf("strm%0d_rdy0", i), 32'(rdy0), 32'd1);
      chk($sformatf("strm%0d_rdy1", i), 32'(rdy1), 32'd1);
      step();
      chk($sformatf("strm%0d_v1", i), 32'(ov1), 32'(vt[i].ev));
      chk($sformatf("strm%0d_pc1", i), opc1, vt[i].epc);
      chk($sformatf("strm%0d_d1", i), 32'(od1), 32'(vt[i].ed));
      chk($sformatf("strm%0d_occ1", i), 32'(occ1), 32'(vt[i].eocc));
      chk($sformatf("strm%0d_v0", i), 32'(ov0), 32'(vt[i].ev));
      chk($sformatf("strm%0d_pc0", i), opc0, vt[i].epc);
      chk($sformatf("strm%0d_occ0", i), 32'(occ0), 32'(vt[i].eocc));
    end

    // stall: A, B taken, C held upstream
    drive(1'b1, 32'h200, 16'h00A, 1'b0, 1'b0);
    step();
    chk("stall_a_occ", 32'(occ1), 32'd1);
    chk("stall_a_rdy", 32'(rdy1), 32'd1);
    drive(1'b1, 32'h204, 16'h00B, 1'b0, 1'b0);
    #1;
    chk("stall_rdy0_comb", 32'(rdy0), 32'd0);
    step();
    chk("stall_b_occ", 32'(occ1), 32'd2);
    chk("stall_b_rdy", 32'(rdy1), 32'd0);
    chk("stall_b_pc", opc1, 32'h200);
    chk("stall_pc0_hold", opc0, 32'h200);
    drive(1'b1, 32'h208, 16'h00C, 1'b0, 1'b0);
    step();
    chk("stall_c_occ", 32'(occ1), 32'd2);
    chk("stall_c_pc", opc1, 32'h200);
    chk("stall_c_data", 32'(od1), 32'h00A);
    out_ready = 1'b1;
    step();
    chk("rel1_pc", opc1, 32'h204);
    chk("rel1_occ", 32'(occ1), 32'd1);
    chk("rel1_rdy", 32'(rdy1), 32'd1);
    step();
    chk("rel2_pc", opc1, 32'h208);
    chk("rel2_data", 32'(od1), 32'h00C);
    chk("rel2_occ", 32'(occ1), 32'd1);
    in_valid = 1'b0;
    step();
    chk("rel3_valid", 32'(ov1), 32'd0);
    chk("rel3_occ", 32'(occ1), 32'd0);

    // flush while full with a same-cycle input
    drive(1'b1, 32'h300, 16'h0E0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h304, 16'h0F0, 1'b0, 1'b0);
    step();
    chk("ff_occ_pre", 32'(occ1), 32'd2);
    drive(1'b1, 32'h308, 16'h0D0, 1'b0, 1'b1);
    step();
    chk("ff_valid", 32'(ov1), 32'd0);
    chk("ff_occ", 32'(occ1), 32'd0);
    chk("ff_data", 32'(od1), 32'(RD));
    chk("ff_pc", opc1, RPC);
    chk("ff_drop", 32'(dc1), 32'd2);
    chk("ff_rdy", 32'(rdy1), 32'd1);
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("ff_nocap", 32'(occ1), 32'd0);

    // flush coinciding with an emit
    drive(1'b1, 32'h400, 16'h040, 1'b0, 1'b0);
    step();
    chk("fe_occ_pre", 32'(occ1), 32'd1);
    drive(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);
    step();
    flush = 1'b0;
    chk("fe_drop", 32'(dc1), 32'd2);
    chk("fe_occ", 32'(occ1), 32'd0);

    // reset mid-operation, with flush also asserted
    fill_flush(1);
    fill_flush(2);
    chk("mid_drop5", 32'(dc1), 32'd5);
    drive(1'b1, 32'h600, 16'h060, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h604, 16'h064, 1'b0, 1'b0);
    step();
    chk("mid_occ2", 32'(occ1), 32'd2);
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    chk("mid_valid", 32'(ov1), 32'd0);
    chk("mid_occ", 32'(occ1), 32'd0);
    chk("mid_drop", 32'(dc1), 32'd0);
    chk("mid_rdy", 32'(rdy1), 32'd1);
    chk("mid_data", 32'(od1), 32'(RD));
    chk("mid_pc", opc1, RPC);

    // saturation of the drop counter
    for (int n = 0; n < 32767; n++) fill_flush(2);
    chk("sat_pre", 32'(dc1), 32'hFFFE);
    fill_flush(1);
    chk("sat_max", 32'(dc1), 32'hFFFF);
    for (int n = 0; n < 3; n++) fill_flush(1);
    chk("sat_hold", 32'(dc1), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
